rv32im_dmem: RTL and testbench

Data-memory responder on the load/store side of the execute stage. It accepts one word-aligned request at a time from the core's load/store path, inserts a programmable number of wait states, performs a byte-lane-masked write or a full-word read on an internal RAM, and returns the response through a valid/ready handshake. It returns raw aligned words. The load/store unit does sub-word lane selection and sign/zero extension.

---
 rtl/rv32im_dmem_pkg.sv | 37 +++
 rtl/rv32im_dmem_if.sv | 29 ++
 rtl/rv32im_dmem_ram.sv | 41 ++++
 rtl/rv32im_dmem.sv | 168 ++++++++++++++++
 tb/tb_rv32im_dmem.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rv32im_dmem_pkg.sv
// Shared definitions for the rv32im data-memory responder.
//   API_DATA_WIDTH / API_ADDR_WIDTH : bus widths of the load/store path
//   dmem_state_e                    : responder FSM encodings
//   DMEM_BE_*                       : byte-enable patterns legal for writes
//   dmem_be_legal()                 : write byte-enable legality check
package rv32im_dmem_pkg;

  localparam int API_DATA_WIDTH = 32;
  localparam int API_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE = 2'd0,
    DMEM_ST_WAIT = 2'd1,
    DMEM_ST_RESP = 2'd2
  } dmem_state_e;

  localparam logic [3:0] DMEM_BE_B0 = 4'b0001;
  localparam logic [3:0] DMEM_BE_B1 = 4'b0010;
  localparam logic [3:0] DMEM_BE_B2 = 4'b0100;
  localparam logic [3:0] DMEM_BE_B3 = 4'b1000;
  localparam logic [3:0] DMEM_BE_H0 = 4'b0011;
  localparam logic [3:0] DMEM_BE_H1 = 4'b1100;
  localparam logic [3:0] DMEM_BE_W  = 4'b1111;

  // Only naturally aligned byte, halfword and word stores are accepted.
  function automatic logic dmem_be_legal(input logic [3:0] be);
    logic ok;
    ok = 1'b0;
    case (be)
      DMEM_BE_B0, DMEM_BE_B1, DMEM_BE_B2, DMEM_BE_B3,
      DMEM_BE_H0, DMEM_BE_H1, DMEM_BE_W: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rv32im_dmem_if.sv
// Request/response bus between the load/store path (master) and the
// data-memory responder (slave).
//   req_*  : one word-aligned request, valid/ready handshake
//   rsp_*  : raw aligned word + fault flag, valid/ready handshake
interface rv32im_dmem_if;
  import rv32im_dmem_pkg::*;

  logic                      req_valid_i;
  logic                      req_ready_o;
  logic                      req_we_i;
  logic [3:0]                req_be_i;
  logic [API_ADDR_WIDTH-1:0] req_addr_i;
  logic [API_DATA_WIDTH-1:0] req_wdata_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [API_DATA_WIDTH-1:0] rsp_rdata_o;
  logic                      rsp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_be_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_be_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface

// File: rtl/rv32im_dmem_ram.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, per-byte write enables,
// registered read data. Contents are not reset.
//   en_i    : access strobe (write when we_i, otherwise read)
//   be_i    : byte-lane write enables
//   idx_i   : word index
//   rdata_o : read data, updated only by a read access and held otherwise
module rv32im_dmem_ram
  import rv32im_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                      clk_i,
  input  logic                      en_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [IDX_W-1:0]          idx_i,
  input  logic [API_DATA_WIDTH-1:0] wdata_i,
  output logic [API_DATA_WIDTH-1:0] rdata_o
);

  logic [API_DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [API_DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) begin
            mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rv32im_dmem.sv
// Data-memory responder for the execute-stage load/store path. Accepts one
// request at a time, waits WAIT_STATES cycles, commits a byte-masked write
// or a full-word read on the internal RAM, and holds the response until the
// requester takes it.
//   clk_i / rst_ni : clock, async active-low reset
//   bus            : rv32im_dmem_if slave (request and response channels)
//
//   state | meaning
//   IDLE  | ready for a request; accepting latches it and checks for faults
//   WAIT  | counting down wait states; commit happens on leaving at count 0
//   RESP  | response valid and held until rsp_ready_i
module rv32im_dmem
  import rv32im_dmem_pkg::*;
#(
  parameter int                        DEPTH_WORDS = 1024,
  parameter logic [API_ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                        WAIT_STATES = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  rv32im_dmem_if.slave bus
);

  localparam int         IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_e               state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      we_q, we_d;
  logic [3:0]                be_q, be_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [API_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      err_q, err_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      rd_ok_q, rd_ok_d;

  logic [API_ADDR_WIDTH-1:0] offset;
  logic                      live_err;
  logic [IDX_W-1:0]          live_idx;
  logic                      commit;
  logic                      c_we, c_err;
  logic [3:0]                c_be;
  logic [IDX_W-1:0]          c_idx;
  logic [API_DATA_WIDTH-1:0] c_wdata;
  logic [API_DATA_WIDTH-1:0] ram_rdata;

  // Unsigned modulo-2^32 offset: addresses below BASE_ADDR wrap to a huge
  // offset and so fall out of range instead of aliasing into the RAM.
  assign offset   = bus.req_addr_i - BASE_ADDR;
  assign live_idx = offset[IDX_W+1:2];
  assign live_err = ((offset >> (IDX_W + 2)) != '0) ||
                    (bus.req_we_i && !dmem_be_legal(bus.req_be_i));

  // With zero wait states the commit edge is the accept edge, so the RAM
  // must see the live request; otherwise it sees the latched copy.
  always_comb begin
    if (state_q == DMEM_ST_IDLE) begin
      c_we    = bus.req_we_i;
      c_be    = bus.req_be_i;
      c_idx   = live_idx;
      c_wdata = bus.req_wdata_i;
      c_err   = live_err;
    end else begin
      c_we    = we_q;
      c_be    = be_q;
      c_idx   = idx_q;
      c_wdata = wdata_q;
      c_err   = err_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    be_d      = be_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rsp_err_d = rsp_err_q;
    rd_ok_d   = rd_ok_q;
    commit    = 1'b0;

    case (state_q)
      DMEM_ST_IDLE: begin
        if (bus.req_valid_i) begin
          we_d    = bus.req_we_i;
          be_d    = bus.req_be_i;
          idx_d   = live_idx;
          wdata_d = bus.req_wdata_i;
          err_d   = live_err;
          if (WAIT_STATES == 0) begin
            state_d = DMEM_ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = DMEM_ST_WAIT;
            cnt_d   = WAIT_M1;
          end
        end
      end
      DMEM_ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DMEM_ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DMEM_ST_RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = DMEM_ST_IDLE;
        end
      end
      default: state_d = DMEM_ST_IDLE;
    endcase

    if (commit) begin
      rsp_err_d = c_err;
      rd_ok_d   = !c_we && !c_err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= DMEM_ST_IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      be_q      <= 4'd0;
      idx_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rsp_err_q <= 1'b0;
      rd_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      be_q      <= be_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rsp_err_q <= rsp_err_d;
      rd_ok_q   <= rd_ok_d;
    end
  end

  // Faulting accesses never touch the RAM, so a bad write cannot corrupt it.
  rv32im_dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (commit && !c_err),
    .we_i    (c_we),
    .be_i    (c_be),
    .idx_i   (c_idx),
    .wdata_i (c_wdata),
    .rdata_o (ram_rdata)
  );

  // RAM read data is not reset and is stale after writes; rd_ok_q gates it
  // so writes, faults and reset all present zero.
  assign bus.req_ready_o = rst_ni && (state_q == DMEM_ST_IDLE);
  assign bus.rsp_valid_o = (state_q == DMEM_ST_RESP);
  assign bus.rsp_rdata_o = rd_ok_q ? ram_rdata : '0;
  assign bus.rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_rv32im_dmem.sv
module tb_rv32im_dmem;
  import rv32im_dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n1, rst_n4;
  logic        sel;          // 0: WAIT_STATES=1 instance, 1: WAIT_STATES=4 instance
  logic        req_valid, req_we, rsp_ready;
  logic [3:0]  req_be;
  logic [31:0] req_addr, req_wdata;

  rv32im_dmem_if bus1();
  rv32im_dmem_if bus4();

  assign bus1.req_valid_i = req_valid & ~sel;
  assign bus4.req_valid_i = req_valid & sel;
  assign bus1.req_we_i    = req_we;
  assign bus4.req_we_i    = req_we;
  assign bus1.req_be_i    = req_be;
  assign bus4.req_be_i    = req_be;
  assign bus1.req_addr_i  = req_addr;
  assign bus4.req_addr_i  = req_addr;
  assign bus1.req_wdata_i = req_wdata;
  assign bus4.req_wdata_i = req_wdata;
  assign bus1.rsp_ready_i = rsp_ready & ~sel;
  assign bus4.rsp_ready_i = rsp_ready & sel;

  wire        o_rdy   = sel ? bus4.req_ready_o : bus1.req_ready_o;
  wire        o_valid = sel ? bus4.rsp_valid_o : bus1.rsp_valid_o;
  wire [31:0] o_rdata = sel ? bus4.rsp_rdata_o : bus1.rsp_rdata_o;
  wire        o_err   = sel ? bus4.rsp_err_o   : bus1.rsp_err_o;

  rv32im_dmem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_dut1 (
    .clk_i (clk), .rst_ni (rst_n1), .bus (bus1));
  rv32im_dmem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(4)) u_dut4 (
    .clk_i (clk), .rst_ni (rst_n4), .bus (bus4));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic we, input logic [3:0] be, input logic [31:0] addr);
    logic bad_be;
    bad_be = we && !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
    return (addr >= 32'h0000_1000) || bad_be;
  endfunction

  // Starts and ends 1 time unit after a rising edge.
  task automatic txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wdata, input int stall);
    exp_t        e;
    int          lat;
    int          ws;
    logic [31:0] key;
    logic [31:0] r0;
    logic        e0;
    ws  = sel ? 4 : 1;
    key = (addr & 32'hFFFF_FFFC) | 32'(sel);
    e.err   = exp_err(we, be, addr);
    e.rdata = 32'h0;
    if (!we && !e.err) e.rdata = mdl.exists(key) ? mdl[key] : 32'h0;
    sb_q.push_back(e);
    if (we && !e.err) begin
      if (!mdl.exists(key)) mdl[key] = 32'h0;
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[key][8*b +: 8] = wdata[8*b +: 8];
    end

    req_we = we; req_be = be; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    chk("ready_before_accept", 32'(o_rdy), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;

    // Valid appears WAIT_STATES edges after the accepting edge.
    lat = 0;
    while (o_valid !== 1'b1 && lat < 40) begin
      chk("ready_low_in_wait", 32'(o_rdy), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(ws));
    chk("ready_low_in_resp", 32'(o_rdy), 32'd0);

    e = sb_q.pop_front();
    chk("rsp_rdata", o_rdata, e.rdata);
    chk("rsp_err", 32'(o_err), 32'(e.err));
    last_rdata = o_rdata;
    r0 = o_rdata;
    e0 = o_err;

    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_rdata", o_rdata, r0);
      chk("bp_err", 32'(o_err), 32'(e0));
      chk("bp_ready", 32'(o_rdy), 32'd0);
    end

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_valid", 32'(o_valid), 32'd0);
    chk("idle_ready", 32'(o_rdy), 32'd1);
  endtask

  initial begin
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    rst_n1 = 1'b0; rst_n4 = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_low", 32'(o_rdy), 32'd0);
    @(negedge clk);
    rst_n1 = 1'b1; rst_n4 = 1'b1;
    #1;
    chk("rst_ready", 32'(o_rdy), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    @(posedge clk); #1;

    // Word round-trip
    txn(1'b1, 4'b1111, 32'h10, 32'hDEAD_BEEF, 0);
    txn(1'b0, 4'b1111, 32'h10, 32'h0, 0);
    chk("roundtrip_literal", last_rdata, 32'hDEAD_BEEF);

    // Byte lanes
    txn(1'b1, 4'b1111, 32'h20, 32'h1122_3344, 0);
    txn(1'b1, 4'b0100, 32'h20, 32'h00AB_0000, 0);
    txn(1'b1, 4'b0010, 32'h20, 32'h0000_CD00, 0);
    txn(1'b0, 4'b1111, 32'h20, 32'h0, 0);
    chk("byte_lane_literal", last_rdata, 32'h11AB_CD44);
    txn(1'b1, 4'b1100, 32'h10, 32'h1234_0000, 0);
    txn(1'b0, 4'b0101, 32'h12, 32'h0, 0);   // read be and addr[1:0] ignored
    chk("halfword_literal", last_rdata, 32'h1234_BEEF);

    // Errors and boundaries
    txn(1'b0, 4'b1111, 32'h1000, 32'h0, 0);
    txn(1'b1, 4'b1111, 32'h30, 32'h0BAD_F00D, 0);
    txn(1'b1, 4'b0101, 32'h30, 32'hFFFF_FFFF, 0);
    txn(1'b1, 4'b0000, 32'h30, 32'hFFFF_FFFF, 0);
    txn(1'b0, 4'b1111, 32'h30, 32'h0, 0);
    chk("bad_be_unchanged", last_rdata, 32'h0BAD_F00D);
    txn(1'b1, 4'b1111, 32'hFFC, 32'hCAFE_0001, 0);
    txn(1'b0, 4'b1111, 32'hFFC, 32'h0, 0);
    txn(1'b1, 4'b1111, 32'h1004, 32'h1, 0);
    txn(1'b0, 4'b1111, 32'hFFFF_FFFC, 32'h0, 0);

    // Backpressure
    txn(1'b0, 4'b1111, 32'h20, 32'h0, 5);
    txn(1'b1, 4'b1111, 32'h1000, 32'h0, 5);

    // Reset mid-WAIT on the four-wait-state instance
    sel = 1'b1;
    txn(1'b1, 4'b1111, 32'h40, 32'h0000_0000, 0);
    req_we = 1'b1; req_be = 4'b1111; req_addr = 32'h40; req_wdata = 32'h5555_5555;
    req_valid = 1'b1;
    chk("wait_rst_accept_ready", 32'(o_rdy), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("wait_rst_in_wait", 32'(o_valid), 32'd0);
    rst_n4 = 1'b0;
    #1;
    chk("wait_rst_ready_low", 32'(o_rdy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n4 = 1'b1;
    #1;
    chk("wait_rst_valid", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    txn(1'b0, 4'b1111, 32'h40, 32'h0, 0);
    chk("wait_rst_no_write", last_rdata, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
